// File: rtl/sdram_req_arbiter_if.sv
// Request/response bundle between the CPU bridge, DMA engine, SDRAM controller front end and the arbiter.
// The slave modport is the arbiter's view and the master modport is the surrounding environment.
interface sdram_req_arbiter_if #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32
);
   logic              cpu_req_valid;
   logic [ADDR_W-1:0] cpu_req_addr;
   logic              cpu_req_rw;
   logic [DATA_W-1:0] cpu_req_wdata;
   logic              cpu_req_ack;
   logic [DATA_W-1:0] cpu_rsp_rdata;

   logic              dma_req_valid;
   logic [ADDR_W-1:0] dma_req_addr;
   logic              dma_req_rw;
   logic [DATA_W-1:0] dma_req_wdata;
   logic              dma_req_ack;
   logic [DATA_W-1:0] dma_rsp_rdata;

   logic              sdram_req_valid;
   logic [ADDR_W-1:0] sdram_req_addr;
   logic              sdram_req_rw;
   logic [DATA_W-1:0] sdram_req_wdata;
   logic              sdram_req_ready;
   logic              sdram_rsp_valid;
   logic [DATA_W-1:0] sdram_rsp_rdata;
   logic              timeout_o;

   modport slave (
      input  cpu_req_valid, cpu_req_addr, cpu_req_rw, cpu_req_wdata,
      output cpu_req_ack, cpu_rsp_rdata,
      input  dma_req_valid, dma_req_addr, dma_req_rw, dma_req_wdata,
      output dma_req_ack, dma_rsp_rdata,
      output sdram_req_valid, sdram_req_addr, sdram_req_rw, sdram_req_wdata,
      input  sdram_req_ready, sdram_rsp_valid, sdram_rsp_rdata,
      output timeout_o
   );

   modport master (
      output cpu_req_valid, cpu_req_addr, cpu_req_rw, cpu_req_wdata,
      input  cpu_req_ack, cpu_rsp_rdata,
      output dma_req_valid, dma_req_addr, dma_req_rw, dma_req_wdata,
      input  dma_req_ack, dma_rsp_rdata,
      input  sdram_req_valid, sdram_req_addr, sdram_req_rw, sdram_req_wdata,
      output sdram_req_ready, sdram_rsp_valid, sdram_rsp_rdata,
      input  timeout_o
   );
endinterface

// File: rtl/sdram_req_arbiter.sv
// CPU/DMA arbiter for the single SDRAM request port: one transaction in flight, bounded read wait.
// Define SDRAM_ARB_CPU_PRIO_EN for fixed CPU priority on ties; the default is round-robin.
module sdram_req_arbiter #(
   parameter int ADDR_W      = 23,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input logic                 wb_clk_i,
   input logic                 wb_rst_ni,
   sdram_req_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, ACK} state_t;

   localparam logic CPU   = 1'b0;
   localparam logic DMA   = 1'b1;
   localparam int   CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   state_t            state, state_nxt;
   logic              owner, grant, pick, cpu_v, dma_v, to_hit;
   logic              mask_cpu, mask_dma, to_flag;
   logic              req_valid_q, req_rw_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic [DATA_W-1:0] req_wdata_q, rdata_q;
   logic [CNT_W-1:0]  cnt;
   logic              ack_cpu, ack_dma;

   // The requester just served is ignored for one IDLE cycle while its valid falls.
   assign cpu_v  = bus.cpu_req_valid & ~mask_cpu;
   assign dma_v  = bus.dma_req_valid & ~mask_dma;
   assign to_hit = (TIMEOUT_CYC != 0) && (int'(cnt) == TIMEOUT_CYC - 1);

`ifdef SDRAM_ARB_CPU_PRIO_EN
   assign pick = cpu_v ? CPU : DMA;
`else
   logic last_grant;

   assign pick = (cpu_v && dma_v) ? ~last_grant : (cpu_v ? CPU : DMA);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni)  last_grant <= DMA;
      else if (grant)  last_grant <= pick;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) state <= IDLE;
      else            state <= state_nxt;

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      case (state)
         IDLE:     if (cpu_v || dma_v) begin
                      grant     = 1'b1;
                      state_nxt = ISSUE;
                   end
         ISSUE:    if (bus.sdram_req_ready) state_nxt = req_rw_q ? ACK : WAIT_RSP;
         WAIT_RSP: if (bus.sdram_rsp_valid || to_hit) state_nxt = ACK;
         ACK:      state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) begin
         owner       <= CPU;
         req_valid_q <= 1'b0;
         req_rw_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         rdata_q     <= '0;
         to_flag     <= 1'b0;
         cnt         <= '0;
         mask_cpu    <= 1'b0;
         mask_dma    <= 1'b0;
      end else begin
         if (grant) begin
            owner       <= pick;
            req_valid_q <= 1'b1;
            req_rw_q    <= pick ? bus.dma_req_rw    : bus.cpu_req_rw;
            req_addr_q  <= pick ? bus.dma_req_addr  : bus.cpu_req_addr;
            req_wdata_q <= pick ? bus.dma_req_wdata : bus.cpu_req_wdata;
            rdata_q     <= '0;
            to_flag     <= 1'b0;
         end
         if (state == ISSUE && bus.sdram_req_ready) begin
            req_valid_q <= 1'b0;
            cnt         <= '0;
         end
         // A response landing on the timeout cycle still wins.
         if (state == WAIT_RSP) begin
            if (bus.sdram_rsp_valid) rdata_q <= bus.sdram_rsp_rdata;
            else if (to_hit) begin
               rdata_q <= DATA_W'(32'hDEAD_BEEF);
               to_flag <= 1'b1;
            end else cnt <= cnt + CNT_W'(1);
         end
         if (state == ACK) begin
            mask_cpu <= (owner == CPU);
            mask_dma <= (owner == DMA);
         end else if (state == IDLE) begin
            mask_cpu <= 1'b0;
            mask_dma <= 1'b0;
         end
      end

   assign ack_cpu = (state == ACK) && (owner == CPU);
   assign ack_dma = (state == ACK) && (owner == DMA);

   assign bus.cpu_req_ack     = ack_cpu;
   assign bus.dma_req_ack     = ack_dma;
   assign bus.cpu_rsp_rdata   = ack_cpu ? rdata_q : '0;
   assign bus.dma_rsp_rdata   = ack_dma ? rdata_q : '0;
   assign bus.timeout_o       = (state == ACK) && to_flag;
   assign bus.sdram_req_valid = req_valid_q;
   assign bus.sdram_req_addr  = req_addr_q;
   assign bus.sdram_req_rw    = req_rw_q;
   assign bus.sdram_req_wdata = req_wdata_q;
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter: rounds of random CPU/DMA traffic against a transaction-level model.
module tb_sdram_req_arbiter;
   localparam int AW = 23;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sdram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .wb_clk_i (clk),
      .wb_rst_ni(rst_n),
      .bus      (bus)
   );

   // dly: read response delay in cycles after accept, 0 = never answered
   typedef struct {
      bit          who;
      logic [AW-1:0] addr;
      bit          rw;
      logic [DW-1:0] wdata;
      int          dly;
      logic [DW-1:0] rdata;
   } txn_t;

   txn_t sq[$];
   txn_t aq[$];
   int   total = 0;
   int   bad = 0;
   bit   force_ready = 1'b0;
   bit   last_dma = 1'b1;
   bit   late_rsp = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit timed_out(input txn_t t);
      return !t.rw && (t.dly == 0 || t.dly > TO);
   endfunction

   function automatic txn_t mk(input bit who, input int rw, input int dly);
      txn_t t;
      t.who   = who;
      t.addr  = AW'($urandom);
      t.rw    = (rw < 0) ? 1'($urandom) : (rw != 0);
      t.wdata = $urandom;
      t.dly   = (dly >= 0) ? dly : (($urandom % 8 == 0) ? 0 : 1 + int'($urandom % 9));
      t.rdata = $urandom;
      return t;
   endfunction

   // ack monitor
   txn_t          mt;
   logic [DW-1:0] m_exp;
   always @(negedge clk) if (rst_n) begin
      if (bus.cpu_req_ack || bus.dma_req_ack) begin
         if (aq.size() == 0) check("ack_unexpected", 64'({bus.cpu_req_ack, bus.dma_req_ack}), 64'(0));
         else begin
            mt    = aq.pop_front();
            m_exp = mt.rw ? '0 : (timed_out(mt) ? 32'hDEAD_BEEF : mt.rdata);
            check("ack_owner", 64'({bus.cpu_req_ack, bus.dma_req_ack}), mt.who ? 64'(1) : 64'(2));
            check("ack_rdata", 64'(mt.who ? bus.dma_rsp_rdata : bus.cpu_rsp_rdata), 64'(m_exp));
            check("other_rdata", 64'(mt.who ? bus.cpu_rsp_rdata : bus.dma_rsp_rdata), 64'(0));
            check("timeout_flag", 64'(bus.timeout_o), 64'(timed_out(mt)));
         end
      end else if (bus.timeout_o || bus.cpu_rsp_rdata != 0 || bus.dma_rsp_rdata != 0)
         check("quiet_outputs", 64'(1), 64'(0));
   end

   // SDRAM controller model
   int   cd = 0;
   bit   rd_busy = 1'b0;
   txn_t cur;
   always @(negedge clk) begin
      if (!rst_n) begin
         cd = 0;
         rd_busy = 1'b0;
         bus.sdram_req_ready = 1'b0;
         bus.sdram_rsp_valid = 1'b0;
         bus.sdram_rsp_rdata = '0;
      end else begin
         if (bus.cpu_req_ack || bus.dma_req_ack) rd_busy = 1'b0;
         bus.sdram_rsp_valid = 1'b0;
         bus.sdram_rsp_rdata = $urandom;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               bus.sdram_rsp_valid = 1'b1;
               bus.sdram_rsp_rdata = cur.rdata;
            end
         end else if (late_rsp) begin
            bus.sdram_rsp_valid = 1'b1;
            late_rsp = 1'b0;
         end else if (!rd_busy && $urandom % 8 == 0) bus.sdram_rsp_valid = 1'b1;
         bus.sdram_req_ready = force_ready || ($urandom % 4 != 0);
         if (bus.sdram_req_valid && bus.sdram_req_ready) begin
            if (sq.size() == 0) check("req_unexpected", 64'(1), 64'(0));
            else begin
               cur = sq.pop_front();
               check("req_addr", 64'(bus.sdram_req_addr), 64'(cur.addr));
               check("req_rw", 64'(bus.sdram_req_rw), 64'(cur.rw));
               check("req_wdata", 64'(bus.sdram_req_wdata), 64'(cur.wdata));
               if (!cur.rw) begin
                  rd_busy = 1'b1;
                  cd = cur.dly;
               end
            end
         end
      end
   end

   task automatic round(input bit dc, input bit dd, input int rw, input int dly, input int exp_lat,
                        input bit fx, input logic [AW-1:0] fa, input logic [DW-1:0] fd);
      txn_t tc, td;
      bit   first_dma, cdone, ddone;
      int   n, cdrop, ddrop;
      tc = mk(1'b0, rw, dly);
      td = mk(1'b1, rw, dly);
      if (fx) begin
         tc.addr = fa;
         if (tc.rw) tc.wdata = fd; else tc.rdata = fd;
      end
`ifdef SDRAM_ARB_CPU_PRIO_EN
      first_dma = !dc;
`else
      first_dma = (dc && dd) ? !last_dma : !dc;
`endif
      if (dc && dd) begin
         if (first_dma) begin sq.push_back(td); sq.push_back(tc); aq.push_back(td); aq.push_back(tc); end
         else           begin sq.push_back(tc); sq.push_back(td); aq.push_back(tc); aq.push_back(td); end
         last_dma = !first_dma;
      end else if (dc) begin sq.push_back(tc); aq.push_back(tc); last_dma = 1'b0; end
      else             begin sq.push_back(td); aq.push_back(td); last_dma = 1'b1; end

      @(negedge clk);
      if (dc) begin
         bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = tc.addr;
         bus.cpu_req_rw = tc.rw;   bus.cpu_req_wdata = tc.wdata;
      end
      if (dd) begin
         bus.dma_req_valid = 1'b1; bus.dma_req_addr = td.addr;
         bus.dma_req_rw = td.rw;   bus.dma_req_wdata = td.wdata;
      end
      cdone = !dc; ddone = !dd; cdrop = 0; ddrop = 0; n = 0;
      while ((!cdone || !ddone || cdrop > 0 || ddrop > 0) && n < 100) begin
         @(negedge clk);
         n++;
         if (cdrop > 0) begin cdrop--; if (cdrop == 0) bus.cpu_req_valid = 1'b0; end
         if (ddrop > 0) begin ddrop--; if (ddrop == 0) bus.dma_req_valid = 1'b0; end
         // served requester keeps valid into the first IDLE cycle, with scrambled fields
         if (bus.cpu_req_ack && !cdone) begin
            cdone = 1'b1; cdrop = 2;
            bus.cpu_req_addr = AW'($urandom); bus.cpu_req_wdata = $urandom;
            if (exp_lat >= 0) check("ack_latency", 64'(n), 64'(exp_lat));
         end
         if (bus.dma_req_ack && !ddone) begin
            ddone = 1'b1; ddrop = 2;
            bus.dma_req_addr = AW'($urandom); bus.dma_req_wdata = $urandom;
            if (exp_lat >= 0) check("ack_latency", 64'(n), 64'(exp_lat));
         end
      end
      if (n >= 100) begin
         check("round_timeout", 64'(1), 64'(0));
         bus.cpu_req_valid = 1'b0;
         bus.dma_req_valid = 1'b0;
      end
      repeat ($urandom % 3) @(negedge clk);
   endtask

   initial begin
      txn_t tr;
      int   v;
      bus.cpu_req_valid = 1'b0; bus.cpu_req_addr = '0; bus.cpu_req_rw = 1'b0; bus.cpu_req_wdata = '0;
      bus.dma_req_valid = 1'b0; bus.dma_req_addr = '0; bus.dma_req_rw = 1'b0; bus.dma_req_wdata = '0;
      bus.sdram_req_ready = 1'b0; bus.sdram_rsp_valid = 1'b0; bus.sdram_rsp_rdata = '0;

      #12;
      check("rst_req_valid", 64'(bus.sdram_req_valid), 64'(0));
      check("rst_req_addr", 64'(bus.sdram_req_addr), 64'(0));
      check("rst_req_wdata", 64'({bus.sdram_req_rw, bus.sdram_req_wdata}), 64'(0));
      check("rst_acks", 64'({bus.cpu_req_ack, bus.dma_req_ack, bus.timeout_o}), 64'(0));
      check("rst_rdata", 64'(bus.cpu_rsp_rdata | bus.dma_rsp_rdata), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      force_ready = 1'b1;
      round(1'b1, 1'b0, 1, 0, 2, 1'b1, 23'h000010, 32'hA5A5_A5A5);
      round(1'b1, 1'b0, 0, 3, 5, 1'b1, 23'h000020, 32'h1234_5678);
      round(1'b1, 1'b0, 0, 0, 2 + TO, 1'b0, '0, '0);
      round(1'b0, 1'b1, 0, TO, 2 + TO, 1'b0, '0, '0);
      repeat (4) round(1'b1, 1'b1, 0, 2, -1, 1'b0, '0, '0);

      // reset while a read sits in WAIT_RSP, then a stray response
      tr = mk(1'b0, 0, 0);
      sq.push_back(tr);
      @(negedge clk);
      bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = tr.addr;
      bus.cpu_req_rw = 1'b0;    bus.cpu_req_wdata = tr.wdata;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_req_valid", 64'(bus.sdram_req_valid), 64'(0));
      check("midrst_acks", 64'({bus.cpu_req_ack, bus.dma_req_ack, bus.timeout_o}), 64'(0));
      check("midrst_rdata", 64'(bus.cpu_rsp_rdata | bus.dma_rsp_rdata), 64'(0));
      check("midrst_accepted", 64'(sq.size()), 64'(0));
      bus.cpu_req_valid = 1'b0;
      last_dma = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b1;
      late_rsp = 1'b1;
      repeat (4) @(negedge clk);
      round(1'b1, 1'b1, -1, -1, -1, 1'b0, '0, '0);

      force_ready = 1'b0;
      repeat (150) begin
         v = 1 + int'($urandom % 3);
         round(v[0], v[1], -1, -1, -1, 1'b0, '0, '0);
      end
      repeat (20) @(negedge clk);
      check("aq_drained", 64'(aq.size()), 64'(0));
      check("sq_drained", 64'(sq.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
